// File: rtl/dyn_pma_table.sv
// Dynamic physical-memory-attribute table: shadow/active region tables with atomic commit and global lock.
// Latency: lookup result and config response are registered, one cycle after acceptance.
// Backpressure: lookup_ready_o and cfg_gnt_o drop while a commit drains and applies (two cycles).
module dyn_pma_table #(
    parameter int unsigned NrRegions = 3,
    parameter int unsigned AddrWidth = 64,
    parameter logic [NrRegions-1:0][AddrWidth-1:0] RstBase   = {64'h8000_0000, 64'h1_0000, 64'h0},
    parameter logic [NrRegions-1:0][AddrWidth-1:0] RstLength = {64'h4000_0000, 64'h1_0000, 64'h1000},
    parameter logic [NrRegions-1:0][3:0]           RstAttr   = {NrRegions{4'b0011}},
    localparam int unsigned CfgAw = $clog2(3*NrRegions+1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cfg_req_i,
    input  logic                 cfg_we_i,
    input  logic [CfgAw-1:0]     cfg_addr_i,
    input  logic [AddrWidth-1:0] cfg_wdata_i,
    output logic                 cfg_gnt_o,
    output logic                 cfg_rvalid_o,
    output logic [AddrWidth-1:0] cfg_rdata_o,
    output logic                 cfg_err_o,
    input  logic                 lookup_valid_i,
    input  logic [AddrWidth-1:0] lookup_addr_i,
    output logic                 lookup_ready_o,
    output logic                 result_valid_o,
    output logic                 result_hit_o,
    output logic                 result_exec_o,
    output logic                 result_cached_o,
    output logic                 result_nonidem_o
);
    localparam int unsigned CtrlIdx = 3 * NrRegions;

    typedef enum logic [1:0] {IDLE, DRAIN, APPLY} state_e;

    state_e state_q, state_d;
    logic   lock_q, lock_d;

    logic [NrRegions-1:0][AddrWidth-1:0] shd_base_q, shd_len_q, act_base_q, act_len_q;
    logic [NrRegions-1:0][3:0]           shd_attr_q, act_attr_q;

    logic                 cfg_rvalid_q, cfg_err_q, cfg_err_d;
    logic [AddrWidth-1:0] cfg_rdata_q, cfg_rdata_d;
    logic                 res_vld_q, res_hit_q, res_exec_q, res_cached_q, res_nonidem_q;
    logic                 res_hit_d;
    logic [3:0]           res_attr_d;

    // Handshake terms derived from the state register only, so they never loop through the FSM logic.
    logic idle, gnt, lk_acc, idx_ok, is_ctrl, shd_we, ctrl_wr, commit;
    assign idle    = (state_q == IDLE);
    assign gnt     = idle & cfg_req_i;
    assign lk_acc  = idle & lookup_valid_i;
    assign idx_ok  = (cfg_addr_i <= CfgAw'(CtrlIdx));
    assign is_ctrl = (cfg_addr_i == CfgAw'(CtrlIdx));
    // Once locked, every write is accepted but dropped.
    assign shd_we  = gnt & cfg_we_i & ~lock_q & idx_ok;
    assign ctrl_wr = shd_we & is_ctrl;
    assign commit  = ctrl_wr & cfg_wdata_i[0];
    // A commit and lock in one write still commits: the lock only affects later accesses.
    assign lock_d  = lock_q | (ctrl_wr & cfg_wdata_i[1]);

    // FSM next state and handshake outputs.
    always_comb begin
        state_d        = state_q;
        lookup_ready_o = 1'b0;
        cfg_gnt_o      = 1'b0;
        case (state_q)
            IDLE: begin
                lookup_ready_o = 1'b1;
                cfg_gnt_o      = cfg_req_i;
                if (commit) state_d = DRAIN;
            end
            DRAIN:   state_d = APPLY;
            APPLY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state and lock register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end

    // Shadow table: written by config accesses to region words.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shd_base_q <= RstBase;
            shd_len_q  <= RstLength;
            shd_attr_q <= RstAttr;
        end else if (shd_we) begin
            for (int r = 0; r < NrRegions; r++) begin
                if (cfg_addr_i == CfgAw'(3*r))   shd_base_q[r] <= cfg_wdata_i;
                if (cfg_addr_i == CfgAw'(3*r+1)) shd_len_q[r]  <= cfg_wdata_i;
                if (cfg_addr_i == CfgAw'(3*r+2)) shd_attr_q[r] <= cfg_wdata_i[3:0];
            end
        end
    end

    // Active table: copied wholesale from the shadow in APPLY; reset abandons any pending commit.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            act_base_q <= RstBase;
            act_len_q  <= RstLength;
            act_attr_q <= RstAttr;
        end else if (state_q == APPLY) begin
            act_base_q <= shd_base_q;
            act_len_q  <= shd_len_q;
            act_attr_q <= shd_attr_q;
        end
    end

    // Config read mux: shadow words, control word {lock, 0}, zero for bad indices.
    always_comb begin
        cfg_rdata_d = '0;
        cfg_err_d   = ~idx_ok;
        if (!cfg_we_i) begin
            for (int r = 0; r < NrRegions; r++) begin
                if (cfg_addr_i == CfgAw'(3*r))   cfg_rdata_d = shd_base_q[r];
                if (cfg_addr_i == CfgAw'(3*r+1)) cfg_rdata_d = shd_len_q[r];
                if (cfg_addr_i == CfgAw'(3*r+2)) cfg_rdata_d = AddrWidth'(shd_attr_q[r]);
            end
            if (is_ctrl) cfg_rdata_d = AddrWidth'({lock_q, 1'b0});
        end
    end

    // Config response register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cfg_rvalid_q <= 1'b0;
            cfg_rdata_q  <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            cfg_rvalid_q <= gnt;
            cfg_rdata_q  <= gnt ? cfg_rdata_d : '0;
            cfg_err_q    <= gnt & cfg_err_d;
        end
    end

    // Region match against the active table; walking downwards leaves the lowest index as winner.
    // End address is formed one bit wider so regions touching the top of the space do not wrap.
    always_comb begin
        logic [AddrWidth:0] top;
        top        = '0;
        res_hit_d  = 1'b0;
        res_attr_d = 4'b1000;
        for (int r = NrRegions - 1; r >= 0; r--) begin
            top = {1'b0, act_base_q[r]} + {1'b0, act_len_q[r]};
            if (act_attr_q[r][0] && (act_len_q[r] != '0) &&
                (lookup_addr_i >= act_base_q[r]) && ({1'b0, lookup_addr_i} < top)) begin
                res_hit_d  = 1'b1;
                res_attr_d = act_attr_q[r];
            end
        end
    end

    // Lookup result register: fields are zero whenever no result is presented.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            res_vld_q     <= 1'b0;
            res_hit_q     <= 1'b0;
            res_exec_q    <= 1'b0;
            res_cached_q  <= 1'b0;
            res_nonidem_q <= 1'b0;
        end else begin
            res_vld_q     <= lk_acc;
            res_hit_q     <= lk_acc & res_hit_d;
            res_exec_q    <= lk_acc & res_attr_d[1];
            res_cached_q  <= lk_acc & res_attr_d[2];
            res_nonidem_q <= lk_acc & res_attr_d[3];
        end
    end

    assign cfg_rvalid_o     = cfg_rvalid_q;
    assign cfg_rdata_o      = cfg_rdata_q;
    assign cfg_err_o        = cfg_err_q;
    assign result_valid_o   = res_vld_q;
    assign result_hit_o     = res_hit_q;
    assign result_exec_o    = res_exec_q;
    assign result_cached_o  = res_cached_q;
    assign result_nonidem_o = res_nonidem_q;
endmodule

// File: tb/tb_dyn_pma_table.sv
// Directed bench for dyn_pma_table: reset, lookups, commit timing, wrap, priority, lock, errors, reset mid-commit.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Result vector order is {valid, hit, exec, cached, nonidem}.
module tb_dyn_pma_table;
    localparam logic [3:0] CTRL = 4'd9;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cfg_req_i = 1'b0, cfg_we_i = 1'b0;
    logic [3:0]  cfg_addr_i = '0;
    logic [63:0] cfg_wdata_i = '0;
    logic        cfg_gnt_o, cfg_rvalid_o, cfg_err_o;
    logic [63:0] cfg_rdata_o;
    logic        lookup_valid_i = 1'b0;
    logic [63:0] lookup_addr_i = '0;
    logic        lookup_ready_o;
    logic        result_valid_o, result_hit_o, result_exec_o, result_cached_o, result_nonidem_o;
    logic [4:0]  res;

    int n_assert = 0;
    int n_fail   = 0;

    assign res = {result_valid_o, result_hit_o, result_exec_o, result_cached_o, result_nonidem_o};

    dyn_pma_table dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i),
        .cfg_gnt_o(cfg_gnt_o), .cfg_rvalid_o(cfg_rvalid_o), .cfg_rdata_o(cfg_rdata_o), .cfg_err_o(cfg_err_o),
        .lookup_valid_i(lookup_valid_i), .lookup_addr_i(lookup_addr_i), .lookup_ready_o(lookup_ready_o),
        .result_valid_o(result_valid_o), .result_hit_o(result_hit_o), .result_exec_o(result_exec_o),
        .result_cached_o(result_cached_o), .result_nonidem_o(result_nonidem_o)
    );

    initial forever #5 clk_i = ~clk_i;

    // One config access; returns on the falling edge where its response is visible.
    task automatic cfg_acc(input logic we, input logic [3:0] idx, input logic [63:0] wd);
        cfg_req_i = 1'b1; cfg_we_i = we; cfg_addr_i = idx; cfg_wdata_i = wd;
        @(negedge clk_i);
        cfg_req_i = 1'b0; cfg_we_i = 1'b0;
    endtask

    // One lookup; returns on the falling edge where its result is visible.
    task automatic lookup(input logic [63:0] a);
        lookup_valid_i = 1'b1; lookup_addr_i = a;
        @(negedge clk_i);
        lookup_valid_i = 1'b0;
    endtask

    // Commit and wait until the FSM is back in IDLE.
    task automatic commit_wait();
        cfg_acc(1'b1, CTRL, 64'h1);
        @(negedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        n_assert++; if (lookup_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", lookup_ready_o); end
        n_assert++; if (res !== 5'b00000) begin n_fail++; $display("FAIL rst_result got %b want 00000", res); end
        n_assert++; if ({cfg_gnt_o, cfg_rvalid_o, cfg_err_o, cfg_rdata_o} !== 67'h0) begin n_fail++; $display("FAIL rst_cfg got %b%b%b %h want all zero", cfg_gnt_o, cfg_rvalid_o, cfg_err_o, cfg_rdata_o); end
        cfg_acc(1'b0, 4'd7, '0);
        n_assert++; if ({cfg_rvalid_o, cfg_err_o, cfg_rdata_o} !== {2'b10, 64'h4000_0000}) begin n_fail++; $display("FAIL rst_read_len2 got %b%b %h want 10 40000000", cfg_rvalid_o, cfg_err_o, cfg_rdata_o); end
        cfg_acc(1'b0, CTRL, '0);
        n_assert++; if ({cfg_rvalid_o, cfg_err_o, cfg_rdata_o} !== {2'b10, 64'h0}) begin n_fail++; $display("FAIL rst_read_ctrl got %b%b %h want 10 0", cfg_rvalid_o, cfg_err_o, cfg_rdata_o); end
        @(negedge clk_i);
        n_assert++; if (cfg_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rvalid_one_cycle got %b want 0", cfg_rvalid_o); end
    endtask

    task automatic test_lookup_basic();
        logic [63:0] addrs [6] = '{64'h8000_1000, 64'h2000, 64'hFFF, 64'h1000, 64'h1_FFFF, 64'h2_0000};
        logic [4:0]  exps  [6] = '{5'b11100, 5'b10001, 5'b11100, 5'b10001, 5'b11100, 5'b10001};
        for (int i = 0; i < 6; i++) begin
            lookup(addrs[i]);
            n_assert++; if (res !== exps[i]) begin n_fail++; $display("FAIL lookup_basic addr=%h got %b want %b", addrs[i], res, exps[i]); end
        end
        @(negedge clk_i);
        n_assert++; if (res !== 5'b00000) begin n_fail++; $display("FAIL result_one_cycle got %b want 00000", res); end
    endtask

    task automatic test_commit();
        cfg_acc(1'b1, 4'd2, 64'h0);
        lookup(64'h0);
        n_assert++; if (res !== 5'b11100) begin n_fail++; $display("FAIL shadow_isolated got %b want 11100", res); end
        // Commit and lookup accepted in the same cycle T.
        cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = CTRL; cfg_wdata_i = 64'h1;
        lookup_valid_i = 1'b1; lookup_addr_i = 64'h0;
        @(negedge clk_i);
        n_assert++; if (res !== 5'b11100) begin n_fail++; $display("FAIL commit_same_cycle_old got %b want 11100", res); end
        cfg_we_i = 1'b0; cfg_addr_i = 4'd0;
        #1;
        n_assert++; if ({lookup_ready_o, cfg_gnt_o} !== 2'b00) begin n_fail++; $display("FAIL drain_handshake got %b want 00", {lookup_ready_o, cfg_gnt_o}); end
        @(negedge clk_i);
        n_assert++; if ({lookup_ready_o, cfg_gnt_o, result_valid_o, cfg_rvalid_o} !== 4'b0000) begin n_fail++; $display("FAIL apply_handshake got %b want 0000", {lookup_ready_o, cfg_gnt_o, result_valid_o, cfg_rvalid_o}); end
        cfg_req_i = 1'b0; lookup_valid_i = 1'b0;
        @(negedge clk_i);
        n_assert++; if (lookup_ready_o !== 1'b1) begin n_fail++; $display("FAIL idle_after_commit got %b want 1", lookup_ready_o); end
        lookup(64'h0);
        n_assert++; if (res !== 5'b10001) begin n_fail++; $display("FAIL commit_applied got %b want 10001", res); end
    endtask

    task automatic test_wrap();
        cfg_acc(1'b1, 4'd3, 64'hFFFF_FFFF_FFFF_F000);
        cfg_acc(1'b1, 4'd4, 64'h2000);
        cfg_acc(1'b1, 4'd6, 64'h0);
        cfg_acc(1'b1, 4'd7, 64'h100);
        cfg_acc(1'b1, 4'd8, 64'h5);
        commit_wait();
        lookup(64'hFFFF_FFFF_FFFF_FFF0);
        n_assert++; if (res !== 5'b11100) begin n_fail++; $display("FAIL wrap_top got %b want 11100", res); end
        lookup(64'h0);
        n_assert++; if (res !== 5'b11010) begin n_fail++; $display("FAIL wrap_zero_region2 got %b want 11010", res); end
        lookup(64'hFFFF_FFFF_FFFF_EFFF);
        n_assert++; if (res !== 5'b10001) begin n_fail++; $display("FAIL wrap_below got %b want 10001", res); end
    endtask

    task automatic test_overlap();
        cfg_acc(1'b1, 4'd0, 64'h0);
        cfg_acc(1'b1, 4'd1, 64'h200);
        cfg_acc(1'b1, 4'd2, 64'hB);
        cfg_acc(1'b1, 4'd3, 64'h80);
        cfg_acc(1'b1, 4'd4, 64'h1000);
        commit_wait();
        lookup(64'h100);
        n_assert++; if (res !== 5'b11101) begin n_fail++; $display("FAIL overlap_lowest got %b want 11101", res); end
        lookup(64'h300);
        n_assert++; if (res !== 5'b11100) begin n_fail++; $display("FAIL overlap_region1 got %b want 11100", res); end
        cfg_acc(1'b1, 4'd1, 64'h0);
        commit_wait();
        lookup(64'h100);
        n_assert++; if (res !== 5'b11100) begin n_fail++; $display("FAIL zero_len_skip got %b want 11100", res); end
        lookup(64'h50);
        n_assert++; if (res !== 5'b11010) begin n_fail++; $display("FAIL zero_len_fallthrough got %b want 11010", res); end
    endtask

    task automatic test_lock_err();
        cfg_acc(1'b0, 4'd10, '0);
        n_assert++; if ({cfg_rvalid_o, cfg_err_o, cfg_rdata_o} !== {2'b11, 64'h0}) begin n_fail++; $display("FAIL bad_read got %b%b %h want 11 0", cfg_rvalid_o, cfg_err_o, cfg_rdata_o); end
        cfg_acc(1'b1, 4'd15, 64'hDEAD);
        n_assert++; if ({cfg_rvalid_o, cfg_err_o} !== 2'b11) begin n_fail++; $display("FAIL bad_write got %b want 11", {cfg_rvalid_o, cfg_err_o}); end
        cfg_acc(1'b1, CTRL, 64'h3);
        n_assert++; if (lookup_ready_o !== 1'b0) begin n_fail++; $display("FAIL lock_commit_drain got %b want 0", lookup_ready_o); end
        @(negedge clk_i); @(negedge clk_i);
        cfg_acc(1'b0, CTRL, '0);
        n_assert++; if (cfg_rdata_o !== 64'h2) begin n_fail++; $display("FAIL lock_read_ctrl got %h want 2", cfg_rdata_o); end
        cfg_acc(1'b1, 4'd0, 64'h1234);
        n_assert++; if ({cfg_rvalid_o, cfg_err_o} !== 2'b10) begin n_fail++; $display("FAIL locked_write_resp got %b want 10", {cfg_rvalid_o, cfg_err_o}); end
        cfg_acc(1'b0, 4'd0, '0);
        n_assert++; if (cfg_rdata_o !== 64'h0) begin n_fail++; $display("FAIL locked_write_ignored got %h want 0", cfg_rdata_o); end
        cfg_acc(1'b1, CTRL, 64'h1);
        n_assert++; if (lookup_ready_o !== 1'b1) begin n_fail++; $display("FAIL locked_commit_ignored got %b want 1", lookup_ready_o); end
        lookup(64'h100);
        n_assert++; if (res !== 5'b11100) begin n_fail++; $display("FAIL locked_table_same got %b want 11100", res); end
    endtask

    task automatic test_reset_mid_commit();
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        cfg_acc(1'b0, CTRL, '0);
        n_assert++; if (cfg_rdata_o !== 64'h0) begin n_fail++; $display("FAIL lock_cleared got %h want 0", cfg_rdata_o); end
        cfg_acc(1'b1, 4'd2, 64'h0);
        cfg_acc(1'b1, CTRL, 64'h1);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        n_assert++; if ({lookup_ready_o, res, cfg_rvalid_o} !== 7'b1000000) begin n_fail++; $display("FAIL post_reset_outputs got %b want 1000000", {lookup_ready_o, res, cfg_rvalid_o}); end
        @(negedge clk_i);
        lookup(64'h0);
        n_assert++; if (res !== 5'b11100) begin n_fail++; $display("FAIL abandon_commit got %b want 11100", res); end
        lookup(64'h8000_1000);
        n_assert++; if (res !== 5'b11100) begin n_fail++; $display("FAIL abandon_region2 got %b want 11100", res); end
        cfg_acc(1'b0, 4'd2, '0);
        n_assert++; if (cfg_rdata_o !== 64'h3) begin n_fail++; $display("FAIL shadow_reset got %h want 3", cfg_rdata_o); end
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        test_reset();
        test_lookup_basic();
        test_commit();
        test_wrap();
        test_overlap();
        test_lock_err();
        test_reset_mid_commit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
